// File: rtl/chan_mux_rr.sv
// +-----------------------------------------------------------------------------+
// | Module : chan_mux_rr                                                         |
// | Desc   : N:1 stream mux (direct or round-robin) into a 1-entry output reg.   |
// |          Optional macro CHAN_MUX_PARITY_EN adds registered out_parity.       |
// | Rev    : 1.0 - initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module chan_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [ADDR_W-1:0]          address,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [ADDR_W-1:0]          out_channel,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef CHAN_MUX_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam logic [0:0]        c_st_empty = 1'b0;
  localparam logic [0:0]        c_st_full  = 1'b1;
  localparam int                c_padw     = 2 ** (ADDR_W + 1);
  localparam logic [ADDR_W:0]   c_chan     = (ADDR_W + 1)'(CHANNELS);
  localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(CHANNELS - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_rr_sel;
  logic [ADDR_W-1:0] w_sel;
  logic              w_rr_hit;
  logic              w_dir_hit;
  logic              w_hit;
  logic              w_can_load;
  logic              w_xfer;
  logic [ADDR_W:0]   w_idx;
  logic [c_padw-1:0] w_valid_pad;
  logic [WIDTH-1:0]  w_data;

  // Padding lets any ADDR_W+1 bit index address the valid vector safely.
  assign w_valid_pad = {{(c_padw - CHANNELS){1'b0}}, in_valid};

  // Scan from the highest offset down so the nearest valid channel to ptr wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_sel = '0;
    w_idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (ADDR_W + 1)'(i);
      if (w_idx >= c_chan) w_idx = w_idx - c_chan;
      if (w_valid_pad[w_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_sel = w_idx[ADDR_W-1:0];
      end
    end
  end

  assign w_dir_hit  = ({1'b0, address} < c_chan);
  assign w_sel      = mode ? w_rr_sel : address;
  assign w_hit      = !reset && (mode ? w_rr_hit : w_dir_hit);
  assign w_can_load = !out_valid || out_ready;
  assign w_xfer     = w_hit && w_can_load && w_valid_pad[{1'b0, w_sel}];

  always_comb begin
    in_ready = '0;
    w_data   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_sel == ADDR_W'(k)) begin
        in_ready[k] = w_hit && w_can_load;
        w_data      = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_empty;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_empty: if (w_xfer) w_state_nxt = c_st_full;
      c_st_full:  if (!w_xfer && out_ready) w_state_nxt = c_st_empty;
      default:    w_state_nxt = c_st_empty;
    endcase
  end

  // Output decode
  always_comb begin
    out_valid = (r_state == c_st_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_channel <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      out_data    <= w_data;
      out_channel <= w_sel;
      if (mode) r_ptr <= (w_sel == c_last) ? '0 : w_sel + ADDR_W'(1);
    end
  end

`ifdef CHAN_MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)       out_parity <= 1'b0;
    else if (w_xfer) out_parity <= ^w_data;
  end
`endif

endmodule

`default_nettype wire
